// File: rtl/spi_rdid_responder_if.sv
// SPI pin bundle and command-status outputs of the Read-ID responder.
//
// Handshake: o_cmd_valid is a one-clk strobe with no ready path. o_cmd_byte
// is valid in that cycle and holds until the next strobe. o_unknown_cmd may
// be high only in a cycle where o_cmd_valid is also high.
interface spi_rdid_responder_if;
    logic       i_spiclk;
    logic       i_spimosi;
    logic       i_chip_select;
    logic       o_spimiso;
    logic       o_miso_oe;
    logic       o_cmd_valid;
    logic [7:0] o_cmd_byte;
    logic       o_unknown_cmd;
    logic       o_busy;
    logic [1:0] state_dbg;

    // The responder, which is the flash-side end of the bus.
    modport slave (
        input  i_spiclk, i_spimosi, i_chip_select,
        output o_spimiso, o_miso_oe, o_cmd_valid, o_cmd_byte,
        output o_unknown_cmd, o_busy, state_dbg
    );

    // The SPI master, or the bench standing in for it.
    modport master (
        output i_spiclk, i_spimosi, i_chip_select,
        input  o_spimiso, o_miso_oe, o_cmd_valid, o_cmd_byte,
        input  o_unknown_cmd, o_busy, state_dbg
    );
endinterface

// File: rtl/spi_rdid_responder.sv
// SPI mode-0 target answering JEDEC Read-ID (0x9F) with a repeating 24-bit ID.
// The SPI pins are oversampled in the clk domain; nothing runs on SCLK.
module spi_rdid_responder #(
    parameter logic [23:0] JEDEC_ID    = 24'h20BA18,
    parameter logic [7:0]  RDID_CMD    = 8'h9F,
    parameter int          SYNC_STAGES = 2
) (
    input logic                 clk,
    input logic                 reset,
    spi_rdid_responder_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RX_CMD = 2'd1,
        TX_ID  = 2'd2,
        IGNORE = 2'd3
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
    logic       sclk_d, cs_d;
    logic       sclk_q, mosi_q, cs_q;
    logic       sclk_rise, sclk_fall, cs_fall;
    logic [7:0] cmd_sr, cmd_full;
    logic [2:0] bit_cnt;
    logic [23:0] id_sr;
    logic [4:0] id_cnt;
    logic       cmd_done;
    logic       miso;
    logic       cmd_valid;
    logic       unknown_cmd;
    logic [7:0] cmd_byte;

    // Input synchronizers plus one delay flop for edge detection. cs_n resets
    // low so a frame already running at reset release is never picked up.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_sync   <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.i_spiclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.i_spimosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.i_chip_select};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            cs_d      <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_q    = sclk_sync[SYNC_STAGES-1];
    assign mosi_q    = mosi_sync[SYNC_STAGES-1];
    assign cs_q      = cs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_q & ~sclk_d;
    assign sclk_fall = ~sclk_q & sclk_d;
    assign cs_fall   = ~cs_q & cs_d;
    assign cmd_full  = {cmd_sr[6:0], mosi_q};

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state; a deasserted chip select overrides any SCLK edge.
    always_comb begin
        state_next = state;
        cmd_done   = 1'b0;
        if (cs_q) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (cs_fall) state_next = RX_CMD;
                RX_CMD: begin
                    if (sclk_rise && bit_cnt == 3'd7) begin
                        cmd_done   = 1'b1;
                        state_next = (cmd_full == RDID_CMD) ? TX_ID : IGNORE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Command shifter, ID shifter and registered MISO.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_sr      <= '0;
            bit_cnt     <= '0;
            id_sr       <= '0;
            id_cnt      <= '0;
            miso        <= 1'b0;
            cmd_valid   <= 1'b0;
            unknown_cmd <= 1'b0;
            cmd_byte    <= '0;
        end else begin
            cmd_valid   <= 1'b0;
            unknown_cmd <= 1'b0;
            if (cs_q) begin
                bit_cnt <= '0;
                id_cnt  <= '0;
                miso    <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (cs_fall) bit_cnt <= '0;
                    RX_CMD: begin
                        if (sclk_rise) begin
                            cmd_sr  <= cmd_full;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (cmd_done) begin
                                cmd_byte    <= cmd_full;
                                cmd_valid   <= 1'b1;
                                unknown_cmd <= (cmd_full != RDID_CMD);
                                if (cmd_full == RDID_CMD) begin
                                    id_sr  <= JEDEC_ID;
                                    id_cnt <= '0;
                                end
                            end
                        end
                    end
                    TX_ID: begin
                        // The ID reloads after bit 0 so it repeats while clocked.
                        if (sclk_fall) begin
                            miso <= id_sr[23];
                            if (id_cnt == 5'd23) begin
                                id_sr  <= JEDEC_ID;
                                id_cnt <= '0;
                            end else begin
                                id_sr  <= {id_sr[22:0], 1'b0};
                                id_cnt <= id_cnt + 5'd1;
                            end
                        end
                    end
                    default: miso <= 1'b0;
                endcase
            end
        end
    end

    assign bus.o_spimiso     = miso;
    assign bus.o_miso_oe     = (state == TX_ID);
    assign bus.o_cmd_valid   = cmd_valid;
    assign bus.o_cmd_byte    = cmd_byte;
    assign bus.o_unknown_cmd = unknown_cmd;
    assign bus.o_busy        = (state != IDLE);
    assign bus.state_dbg     = state;

endmodule

// File: tb/tb_spi_rdid_responder.sv
// Directed bench for spi_rdid_responder: a behavioural SPI master drives
// frames, expected command bytes and MISO bits go through scoreboard queues.
module tb_spi_rdid_responder;

    localparam logic [23:0] ID   = 24'h20BA18;
    localparam logic [7:0]  RDID = 8'h9F;

    logic clk;
    logic reset;
    spi_rdid_responder_if bus ();

    spi_rdid_responder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock and reset driver.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int half = 2;
    int valid_cnt = 0;
    int base_cnt;
    logic prev_valid = 1'b0;
    logic [8:0] exp_cmd_q[$];
    logic [1:0] exp_q[$];
    logic [8:0] exp_cmd;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCLK period: low phase with MOSI set, high phase, then MISO/OE are
    // sampled just before the falling edge.
    task automatic spi_bit(input string tag, input logic mosi_bit, input logic chk,
                           input logic [1:0] exp);
        logic [1:0] e;
        if (chk) exp_q.push_back(exp);
        bus.i_spimosi = mosi_bit;
        tick(half);
        bus.i_spiclk = 1'b1;
        tick(half);
        if (chk) begin
            e = exp_q.pop_front();
            check(tag, {bus.o_miso_oe, bus.o_spimiso}, e);
        end
        bus.i_spiclk = 1'b0;
    endtask

    task automatic frame_begin();
        bus.i_chip_select = 1'b0;
        tick(4);
    endtask

    // cs_n high for the minimum gap of SYNC_STAGES+2 clk.
    task automatic frame_end();
        tick(2);
        bus.i_chip_select = 1'b1;
        tick(4);
    endtask

    task automatic send_cmd(input logic [7:0] c);
        exp_cmd_q.push_back({c != RDID, c});
        for (int i = 7; i >= 0; i--)
            spi_bit("cmd_phase_miso", c[i], i != 0, 2'b00);
    endtask

    // Clock n data bits; tx=1 expects pattern MSB first with OE high,
    // tx=0 expects MISO and OE low.
    task automatic read_bits(input int n, input logic [47:0] pattern, input logic tx);
        for (int i = 0; i < n; i++)
            spi_bit(tx ? "id_bit" : "quiet_bit", 1'($urandom_range(0, 1)), 1'b1,
                    tx ? {1'b1, pattern[n-1-i]} : 2'b00);
    endtask

    // Command scoreboard: every strobe pops one expected {unknown, cmd}.
    always @(negedge clk) begin
        if (bus.o_cmd_valid) begin
            valid_cnt++;
            check("cmd_valid_width", {47'd0, prev_valid}, 48'd0);
            if (exp_cmd_q.size() == 0) begin
                check("unexpected_cmd_valid", exp_cmd_q.size(), 1);
            end else begin
                exp_cmd = exp_cmd_q.pop_front();
                check("cmd_byte", bus.o_cmd_byte, exp_cmd[7:0]);
                check("unknown_cmd", bus.o_unknown_cmd, exp_cmd[8]);
            end
        end else if (bus.o_unknown_cmd) begin
            check("unknown_without_valid", bus.o_cmd_valid, 1);
        end
        prev_valid = bus.o_cmd_valid;
    end

    // Directed sequence.
    initial begin
        reset = 1'b1;
        bus.i_spiclk = 1'b0;
        bus.i_spimosi = 1'b0;
        bus.i_chip_select = 1'b1;
        tick(3);
        check("reset_outputs",
              {bus.o_spimiso, bus.o_miso_oe, bus.o_cmd_valid, bus.o_cmd_byte,
               bus.o_unknown_cmd, bus.o_busy, bus.state_dbg}, 48'd0);
        reset = 1'b0;
        tick(4);

        // Read-ID at a slower SCLK.
        half = 3;
        frame_begin();
        send_cmd(RDID);
        read_bits(24, {24'd0, ID}, 1'b1);
        frame_end();

        // Unknown command: quiet bus, busy until cs_n high.
        frame_begin();
        send_cmd(8'h05);
        read_bits(16, 48'd0, 1'b0);
        check("busy_in_ignore", bus.o_busy, 1);
        frame_end();
        check("idle_after_ignore", bus.o_busy, 0);

        // Aborted command after 5 bits.
        half = 2;
        base_cnt = valid_cnt;
        frame_begin();
        for (int i = 0; i < 5; i++) spi_bit("abort_miso", 1'b1, 1'b1, 2'b00);
        bus.i_chip_select = 1'b1;
        tick(4);
        check("busy_after_abort", bus.o_busy, 0);
        check("no_valid_on_abort", valid_cnt, base_cnt);
        frame_begin();
        send_cmd(RDID);
        read_bits(24, {24'd0, ID}, 1'b1);
        frame_end();

        // 48 bits: the ID repeats.
        frame_begin();
        send_cmd(RDID);
        read_bits(48, {ID, ID}, 1'b1);
        frame_end();

        // Reset mid-ID with cs_n held low.
        frame_begin();
        send_cmd(RDID);
        read_bits(10, {38'd0, ID[23:14]}, 1'b1);
        reset = 1'b1;
        tick(1);
        check("reset_mid_frame",
              {bus.o_spimiso, bus.o_miso_oe, bus.o_cmd_valid, bus.o_cmd_byte,
               bus.o_unknown_cmd, bus.o_busy, bus.state_dbg}, 48'd0);
        reset = 1'b0;
        read_bits(8, 48'd0, 1'b0);
        check("busy_after_reset", bus.o_busy, 0);
        bus.i_chip_select = 1'b1;
        tick(4);
        frame_begin();
        send_cmd(RDID);
        read_bits(24, {24'd0, ID}, 1'b1);
        frame_end();

        // Back-to-back frames, minimum cs_n gap, SCLK = clk/4.
        base_cnt = valid_cnt;
        frame_begin();
        send_cmd(RDID);
        read_bits(24, {24'd0, ID}, 1'b1);
        frame_end();
        frame_begin();
        send_cmd(RDID);
        read_bits(24, {24'd0, ID}, 1'b1);
        frame_end();
        check("back_to_back_valids", valid_cnt - base_cnt, 2);

        tick(4);
        check("cmd_queue_drained", exp_cmd_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
